// File: rtl/matmul_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared 2x2 multiply engine.
// master: the requester/engine environment; slave: the arbiter.
interface matmul_arbiter_if;
  // requester side
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_c, rsp1_c;
  logic        rsp0_err, rsp1_err;
  // engine side
  logic        eng_start;
  logic [15:0] eng_a, eng_b;
  logic [31:0] eng_c;
  logic        eng_done;
  // status
  logic        busy;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, eng_c, eng_done,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp0_c, rsp1_c, rsp0_err, rsp1_err,
    input  eng_start, eng_a, eng_b, busy
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, eng_c, eng_done,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp0_c, rsp1_c, rsp0_err, rsp1_err,
    output eng_start, eng_a, eng_b, busy
  );
endinterface

// File: rtl/matmul_arbiter.sv
// Two-requester round-robin front end for a shared 2x2 4-bit matrix multiply
// engine. One operation in flight; engine completion or a WAIT timeout ends it.
module matmul_arbiter #(
  parameter int TIMEOUT = 31
) (
  input logic            clk,
  input logic            rst_n,
  matmul_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e           state_q;
  logic [7:0]       timer_q, timer_d;
  logic             owner_q, last_q;
  logic [15:0]      a_q, b_q;
  logic [31:0]      res_q;
  logic             err_q, start_q;
  logic [1:0]       rsp_vld_q;

  logic [1:0]       req_vld, req_rdy, rsp_rdy;
  logic [1:0][15:0] req_a, req_b;
  logic             grant, hs;

  assign req_vld = {bus.req1_valid, bus.req0_valid};
  assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a   = {bus.req1_a, bus.req0_a};
  assign req_b   = {bus.req1_b, bus.req0_b};
  assign timer_d = timer_q + 8'd1;

  // Grant: the lone valid requester, or on a tie the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req_vld == 2'b11) grant = ~last_q;
    else if (req_vld[1])  grant = 1'b1;
  end

  // Ready is combinational so a request is taken the cycle it shows up in IDLE;
  // gated by rst_n so it is low the instant reset asserts.
  assign hs      = rst_n && (state_q == IDLE) && (|req_vld);
  assign req_rdy = hs ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // Operation sequencing: accept, pulse the engine, wait for done/timeout, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      rsp_vld_q <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            owner_q <= grant;
            a_q     <= req_a[grant];
            b_q     <= req_b[grant];
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // done takes priority over a coincident timeout
          if (bus.eng_done) begin
            res_q     <= bus.eng_c;
            err_q     <= 1'b0;
            rsp_vld_q <= owner_q ? 2'b10 : 2'b01;
            state_q   <= RESP;
          end else if (timer_d == TO) begin
            res_q     <= '0;
            err_q     <= 1'b1;
            rsp_vld_q <= owner_q ? 2'b10 : 2'b01;
            state_q   <= RESP;
          end else begin
            timer_q <= timer_d;
          end
        end
        RESP: begin
          if (rsp_rdy[owner_q]) begin
            rsp_vld_q <= '0;
            last_q    <= owner_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = req_rdy[0];
  assign bus.req1_ready = req_rdy[1];
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_c     = res_q;
  assign bus.rsp1_c     = res_q;
  assign bus.rsp0_err   = rsp_vld_q[0] & err_q;
  assign bus.rsp1_err   = rsp_vld_q[1] & err_q;
  assign bus.eng_start  = start_q;
  assign bus.eng_a      = a_q;
  assign bus.eng_b      = b_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_matmul_arbiter.sv
// Bench for matmul_arbiter: transaction-timestamp reference model, engine model
// with programmable latency, directed scenarios plus a randomized run.
module tb_matmul_arbiter;
  localparam int T = 31;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  matmul_arbiter_if bus();
  matmul_arbiter #(.TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {int t; logic [31:0] c;} pulse_t;
  pulse_t pq[$];

  int cyc, n_vec, n_err, n_start, n_v0;
  // reference model: current transaction described by timestamps
  bit          m_act, m_own, m_last, m_err;
  int          m_h, m_rs;
  logic [15:0] m_a, m_b;
  logic [31:0] m_c;
  int          force_lat = -1;
  bit          p0, p1;
  int          order[$];
  logic [31:0] rc_log[$];
  bit          re_log[$];
  int          t_start, t_rsp;

  function automatic logic [31:0] mm(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = int'(a[4*(2*i)+:4]) * int'(b[4*j+:4]) + int'(a[4*(2*i+1)+:4]) * int'(b[4*(2+j)+:4]);
        r[8*(2*i+j)+:8] = s[7:0];
      end
    return r;
  endfunction

  function automatic int pick_lat();
    int r;
    if (force_lat >= 0) return force_lat;
    r = $urandom_range(0, 9);
    case (r)
      0:       return 1;
      1:       return T;
      2:       return T + $urandom_range(1, 3);
      default: return $urandom_range(1, T);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, compare every output to the model, then advance the model.
  task automatic cycle(input bit v0, input bit v1, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, input bit rr0, input bit rr1);
    logic [1:0]  exp_rdy, rv;
    logic [31:0] ec;
    bit          done;
    int          lat;
    @(posedge clk);
    cyc++;
    #1;
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.req0_a = a0; bus.req0_b = b0; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp0_ready = rr0; bus.rsp1_ready = rr1;
    done = 1'b0;
    ec = $urandom;
    foreach (pq[i]) if (pq[i].t == cyc) begin done = 1'b1; ec = pq[i].c; end
    for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].t <= cyc) pq.delete(i);
    bus.eng_done = done;
    bus.eng_c = ec;
    #1;
    exp_rdy = 2'b00;
    if (!m_act) begin
      if (v0 && (!v1 || m_last))       exp_rdy = 2'b01;
      else if (v1 && (!v0 || !m_last)) exp_rdy = 2'b10;
    end
    rv = (m_act && cyc >= m_rs) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
    chk("ready", 64'({bus.req1_ready, bus.req0_ready}), 64'(exp_rdy));
    chk("busy", 64'(bus.busy), 64'(m_act));
    chk("eng_start", 64'(bus.eng_start), 64'(m_act && cyc == m_h + 1));
    chk("eng_ab", 64'({bus.eng_a, bus.eng_b}), 64'({m_a, m_b}));
    chk("rsp_valid", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'(rv));
    if (rv != 2'b00)
      chk("rsp_c_err", m_own ? 64'({bus.rsp1_c, bus.rsp1_err}) : 64'({bus.rsp0_c, bus.rsp0_err}),
          64'({m_c, m_err}));
    if (bus.eng_start) n_start++;
    if (bus.rsp0_valid) n_v0++;
    if (rv != 2'b00 && cyc == m_rs) t_rsp = cyc;
    if (exp_rdy != 2'b00) begin
      m_act = 1'b1;
      m_h = cyc;
      m_own = exp_rdy[1];
      m_a = m_own ? a1 : a0;
      m_b = m_own ? b1 : b0;
      lat = pick_lat();
      m_err = (lat > T);
      m_c = m_err ? 32'h0 : mm(m_a, m_b);
      m_rs = cyc + 2 + (m_err ? T : lat);
      pq.push_back('{cyc + 1 + lat, mm(m_a, m_b)});
      order.push_back(int'(m_own));
      t_start = cyc + 1;
      if (m_own) p1 = 1'b0; else p0 = 1'b0;
    end else if (rv != 2'b00 && (m_own ? rr1 : rr0)) begin
      rc_log.push_back(m_own ? bus.rsp1_c : bus.rsp0_c);
      re_log.push_back(m_own ? bus.rsp1_err : bus.rsp0_err);
      m_act = 1'b0;
      m_last = m_own;
    end
  endtask

  task automatic run_pending(input int n, input logic [15:0] a0, input logic [15:0] b0,
                             input logic [15:0] a1, input logic [15:0] b1, input bit rr);
    for (int i = 0; i < n; i++) cycle(p0, p1, a0, b0, a1, b1, rr, rr);
  endtask

  task automatic clear_logs();
    order.delete(); rc_log.delete(); re_log.delete();
    n_start = 0; n_v0 = 0;
  endtask

  task automatic apply_reset(input bit hold);
    bus.req0_valid = hold;
    bus.req1_valid = hold;
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                        bus.rsp0_err, bus.rsp1_err, bus.eng_start, bus.busy}), 64'(0));
    chk("rst_rsp_c", 64'({bus.rsp0_c, bus.rsp1_c}), 64'(0));
    chk("rst_eng", 64'({bus.eng_a, bus.eng_b}), 64'(0));
    repeat (2) begin @(posedge clk); cyc++; end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #2 rst_n = 1'b1;
    m_act = 1'b0; m_last = 1'b1; m_a = '0; m_b = '0;
  endtask

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    bus.eng_c = 0; bus.eng_done = 0;
    #2 apply_reset(1'b0);

    // single op, 10-cycle engine
    clear_logs(); force_lat = 10; p0 = 1; p1 = 0;
    run_pending(20, 16'h4321, 16'h8765, 16'h0000, 16'h0000, 1'b1);
    chk("r033_starts", 64'(n_start), 64'(1));
    chk("r033_nrsp", 64'(rc_log.size()), 64'(1));
    if (rc_log.size() == 1) begin
      chk("r033_c", 64'(rc_log[0]), 64'h322B1613);
      chk("r033_err", 64'(re_log[0]), 64'(0));
    end

    // simultaneous requests straight out of reset
    apply_reset(1'b0);
    clear_logs(); force_lat = 3; p0 = 1; p1 = 1;
    run_pending(30, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("r034_nops", 64'(order.size()), 64'(2));
    if (order.size() == 2 && rc_log.size() == 2) begin
      chk("r034_first", 64'(order[0]), 64'(0));
      chk("r034_second", 64'(order[1]), 64'(1));
      chk("r034_c0", 64'(rc_log[0]), 64'hC2C2C2C2);
      chk("r034_c1", 64'(rc_log[1]), 64'hC2C2C2C2);
    end

    // both held valid: strict alternation
    clear_logs(); force_lat = 2;
    for (int i = 0; i < 26; i++)
      cycle(1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b1);
    chk("r035_nops", 64'(order.size() >= 4), 64'(1));
    if (order.size() >= 4)
      chk("r035_abab", 64'({order[0][0], order[1][0], order[2][0], order[3][0]}), 64'(4'b0101));

    // engine silent -> timeout; its late done lands in IDLE
    while (m_act) cycle(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    clear_logs(); force_lat = 40; p0 = 0; p1 = 1;
    run_pending(60, 16'h0000, 16'h0000, 16'h1234, 16'h5678, 1'b1);
    chk("r036_lat", 64'(t_rsp - t_start), 64'(32));
    chk("r036_nrsp", 64'(rc_log.size()), 64'(1));
    if (rc_log.size() == 1) begin
      chk("r036_c", 64'(rc_log[0]), 64'(0));
      chk("r036_err", 64'(re_log[0]), 64'(1));
    end

    // response back-pressure with req1 knocking
    clear_logs(); force_lat = 5;
    for (int i = 0; i < 30; i++)
      cycle(i == 0, 1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b0);
    chk("r037_held", 64'(n_v0), 64'(23));
    cycle(1'b0, 1'b1, 16'h0, 16'h0, 16'h3333, 16'h4444, 1'b1, 1'b1);
    p0 = 0; p1 = 1;
    run_pending(15, 16'h0, 16'h0, 16'h3333, 16'h4444, 1'b1);
    chk("r037_nrsp", 64'(rc_log.size()), 64'(2));

    // reset in WAIT aborts; stale done afterwards does nothing
    clear_logs(); force_lat = 20; p0 = 1; p1 = 0;
    run_pending(8, 16'h5555, 16'h6666, 16'h0, 16'h0, 1'b1);
    #3 apply_reset(1'b1);
    p0 = 0; p1 = 0;
    run_pending(40, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("r038_nrsp", 64'(rc_log.size()), 64'(0));

    // randomized traffic
    force_lat = -1;
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
